// File: rtl/circle_path_sequencer_if.sv
// Control/status bundle between the animation controller and whoever drives it.
// The master side supplies run/step controls; the slave side (the sequencer)
// returns the registered row/col select pair and status pulses.
interface circle_path_sequencer_if #(
  parameter int DISPLAY_COUNT = 6,
  parameter int DIV_WIDTH     = 24,
  parameter int COL_WIDTH     = $clog2(DISPLAY_COUNT)
);
  logic                 enable;
  logic                 dir;
  logic [DIV_WIDTH-1:0] step_div;
  logic                 step_req;
  logic                 clear;
  logic                 row;
  logic [COL_WIDTH-1:0] col;
  logic                 step_pulse;
  logic                 lap_pulse;
  logic                 running;

  modport master (
    output enable, dir, step_div, step_req, clear,
    input  row, col, step_pulse, lap_pulse, running
  );

  modport slave (
    input  enable, dir, step_div, step_req, clear,
    output row, col, step_pulse, lap_pulse, running
  );
endinterface

// File: rtl/circle_path_sequencer.sv
// Orbit sequencer for the circle-on-7-segment bank: walks a position p over
// 0..2N-1 (top row left-to-right, bottom row right-to-left) and presents it
// as a registered row/col pair for the seg7 driver, with a programmable step
// period, direction, run/pause, single-step and synchronous clear.
module circle_path_sequencer #(
  parameter int DISPLAY_COUNT = 6,
  parameter int COL_WIDTH     = $clog2(DISPLAY_COUNT),
  parameter int DIV_WIDTH     = 24,
  parameter int POS_WIDTH     = $clog2(2*DISPLAY_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  circle_path_sequencer_if.slave  bus
);

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  // Orbit landmarks: last position before wrap, first bottom-row position
  localparam logic [POS_WIDTH-1:0] POS_LAST = POS_WIDTH'(2*DISPLAY_COUNT - 1);
  localparam logic [POS_WIDTH-1:0] POS_HALF = POS_WIDTH'(DISPLAY_COUNT);

  logic [1:0]           state_reg, state_next;
  logic [DIV_WIDTH-1:0] div_reg, div_next;
  logic [POS_WIDTH-1:0] pos_reg, pos_next, pos_step;
  logic                 advance;
  logic                 wrap;
  logic                 row_reg, row_next;
  logic [COL_WIDTH-1:0] col_reg, col_next;
  logic [POS_WIDTH-1:0] col_full;
  logic                 step_pulse_reg;
  logic                 lap_pulse_reg;
  logic                 running_reg;

  // Controller next-state and divider: decides whether this edge advances p
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    advance    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        div_next = '0;
        if (bus.enable) begin
          state_next = ST_RUN;
        end else if (bus.step_req) begin
          state_next = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!bus.enable) begin
          state_next = ST_IDLE;
          div_next   = '0;
        end else if (div_reg >= bus.step_div) begin
          // >= rather than == so a period shortened below the running
          // count fires on the next edge instead of wrapping the counter
          div_next = '0;
          advance  = 1'b1;
        end else begin
          div_next = div_reg + DIV_WIDTH'(1);
        end
      end
      ST_STEP: begin
        advance    = 1'b1;
        div_next   = '0;
        state_next = bus.enable ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        div_next   = '0;
      end
    endcase
    // Clear resets position and period but leaves the mode alone
    if (bus.clear) begin
      state_next = state_reg;
      div_next   = '0;
      advance    = 1'b0;
    end
  end

  // Neighbour position in the selected direction, flagging the lap wrap
  always_comb begin
    pos_step = pos_reg;
    wrap     = 1'b0;
    if (bus.dir) begin
      if (pos_reg >= POS_LAST) begin
        pos_step = '0;
        wrap     = 1'b1;
      end else begin
        pos_step = pos_reg + POS_WIDTH'(1);
      end
    end else begin
      if (pos_reg == '0) begin
        pos_step = POS_LAST;
        wrap     = 1'b1;
      end else begin
        pos_step = pos_reg - POS_WIDTH'(1);
      end
    end
  end

  // Next position and its row/col mapping (bottom row runs right-to-left)
  always_comb begin
    pos_next = pos_reg;
    if (bus.clear) begin
      pos_next = '0;
    end else if (advance) begin
      pos_next = pos_step;
    end
    row_next = (pos_next >= POS_HALF);
    col_full = row_next ? (POS_LAST - pos_next) : pos_next;
    col_next = COL_WIDTH'(col_full);
  end

  // Controller state and divider registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      div_reg   <= '0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
    end
  end

  // Orbit position and the registered row/col select pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_reg <= '0;
      row_reg <= 1'b0;
      col_reg <= '0;
    end else begin
      pos_reg <= pos_next;
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  // Status outputs, aligned with the edge that shows the new position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_pulse_reg <= 1'b0;
      lap_pulse_reg  <= 1'b0;
      running_reg    <= 1'b0;
    end else begin
      step_pulse_reg <= advance;
      lap_pulse_reg  <= advance & wrap;
      running_reg    <= (state_next == ST_RUN);
    end
  end

  assign bus.row        = row_reg;
  assign bus.col        = col_reg;
  assign bus.step_pulse = step_pulse_reg;
  assign bus.lap_pulse  = lap_pulse_reg;
  assign bus.running    = running_reg;

endmodule

// File: tb/tb_circle_path_sequencer.sv
// Bench for circle_path_sequencer: orbit-table reference model checked every
// cycle, plus directed scenarios with hand-computed positions and timings.
module tb_circle_path_sequencer;

  localparam int N  = 6;
  localparam int DW = 24;

  logic clk;
  logic rst_n;

  circle_path_sequencer_if #(.DISPLAY_COUNT(N), .DIV_WIDTH(DW)) bus ();

  circle_path_sequencer #(.DISPLAY_COUNT(N), .DIV_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Orbit as an explicit list of (row,col) stops; the model walks an index
  // into this list.
  int orow [2*N];
  int ocol [2*N];
  initial begin
    for (int i = 0; i < N; i++) begin
      orow[i] = 0;       ocol[i] = i;
      orow[N+i] = 1;     ocol[N+i] = N-1-i;
    end
  end

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2;
  int m_idx, m_mode, m_wait;
  bit m_step, m_lap;

  always @(posedge clk or negedge rst_n) begin : model_blk
    int idx, mode, wt;
    bit sp, lp, go;
    if (!rst_n) begin
      m_idx <= 0; m_mode <= M_IDLE; m_wait <= 0; m_step <= 0; m_lap <= 0;
    end else begin
      idx = m_idx; mode = m_mode; wt = m_wait; sp = 0; lp = 0; go = 0;
      if (bus.clear) begin
        idx = 0; wt = 0;
      end else if (mode == M_IDLE) begin
        wt = 0;
        if (bus.enable) mode = M_RUN;
        else if (bus.step_req) mode = M_STEP;
      end else if (mode == M_RUN) begin
        if (!bus.enable) begin mode = M_IDLE; wt = 0; end
        else if (wt >= int'(bus.step_div)) begin go = 1; wt = 0; end
        else wt = wt + 1;
      end else begin
        go = 1; wt = 0;
        mode = bus.enable ? M_RUN : M_IDLE;
      end
      if (go) begin
        sp = 1;
        if (bus.dir) begin
          idx = (idx + 1) % (2*N);
          lp = (idx == 0);
        end else begin
          lp = (idx == 0);
          idx = (idx + 2*N - 1) % (2*N);
        end
      end
      m_idx <= idx; m_mode <= mode; m_wait <= wt; m_step <= sp; m_lap <= lp;
    end
  end

  // Per-cycle comparison against the model, one log line per step
  always @(negedge clk) begin
    chk("row", int'(bus.row), orow[m_idx]);
    chk("col", int'(bus.col), ocol[m_idx]);
    chk("step_pulse", int'(bus.step_pulse), int'(m_step));
    chk("lap_pulse", int'(bus.lap_pulse), int'(m_lap));
    chk("running", int'(bus.running), int'(m_mode == M_RUN));
    if (bus.step_pulse)
      $display("[TB] step t=%0t row=%0d col=%0d lap=%0d", $time, bus.row, bus.col, bus.lap_pulse);
  end

  // ---------------- directed helpers ----------------
  int pos_q[$];
  int lap_at;
  int first_at, last_at;

  task automatic collect(input int n, input int budget);
    pos_q.delete(); lap_at = -1; first_at = -1; last_at = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.step_pulse) begin
        if (bus.lap_pulse) lap_at = pos_q.size();
        pos_q.push_back(int'(bus.row) * 8 + int'(bus.col));
        if (first_at < 0) first_at = i;
        last_at = i;
        if (pos_q.size() == n) break;
      end
    end
  endtask

  task automatic wait_gap(output int gap, input int budget);
    gap = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.step_pulse) begin gap = i; break; end
    end
  endtask

  // One single-step request; returns what appeared on the advance edge
  task automatic do_step(output int sp, output int pos, output int lp);
    bus.step_req = 1'b1;
    @(negedge clk);
    bus.step_req = 1'b0;
    @(negedge clk);
    sp  = int'(bus.step_pulse);
    lp  = int'(bus.lap_pulse);
    pos = int'(bus.row) * 8 + int'(bus.col);
    repeat (3) @(negedge clk);
  endtask

  int exp_cw [12] = '{1, 2, 3, 4, 5, 13, 12, 11, 10, 9, 8, 0};

  initial begin
    int sp, pos, lp, gap, cnt;
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.dir = 1'b1; bus.step_div = 24'd3;
    bus.step_req = 1'b0; bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_row", int'(bus.row), 0);
    chk("rst_col", int'(bus.col), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_step", int'(bus.step_pulse), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clockwise full lap, step_div=3
    bus.enable = 1'b1;
    collect(12, 80);
    bus.enable = 1'b0;
    chk("cw_count", pos_q.size(), 12);
    for (int i = 0; i < 12 && i < pos_q.size(); i++) chk("cw_pos", pos_q[i], exp_cw[i]);
    chk("cw_lap_index", lap_at, 11);
    chk("cw_first_at", first_at, 5);
    chk("cw_span", last_at - first_at, 44);
    @(negedge clk);
    chk("paused_running", int'(bus.running), 0);

    // Counter-clockwise single steps from (0,0)
    bus.dir = 1'b0;
    do_step(sp, pos, lp);
    chk("ccw1_pulse", sp, 1); chk("ccw1_pos", pos, 8);  chk("ccw1_lap", lp, 1);
    do_step(sp, pos, lp);
    chk("ccw2_pulse", sp, 1); chk("ccw2_pos", pos, 9);  chk("ccw2_lap", lp, 0);
    do_step(sp, pos, lp);
    chk("ccw3_pulse", sp, 1); chk("ccw3_pos", pos, 10); chk("step_running", int'(bus.running), 0);

    // Clear, step to (0,3), then reverse
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clr_pos", int'(bus.row) * 8 + int'(bus.col), 0);
    bus.dir = 1'b1;
    repeat (3) do_step(sp, pos, lp);
    chk("at_03", pos, 3);
    bus.dir = 1'b0;
    do_step(sp, pos, lp);
    chk("rev_02", pos, 2);

    // step_req held during RUN adds nothing: 4 advances in 20 edges
    bus.dir = 1'b1; bus.step_div = 24'd3;
    bus.enable = 1'b1; bus.step_req = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (bus.step_pulse) cnt++; end
    bus.enable = 1'b0; bus.step_req = 1'b0;
    chk("run_ignores_step_req", cnt, 4);
    repeat (2) @(negedge clk);

    // Shrinking step_div mid-run
    bus.step_div = 24'd100;
    bus.enable = 1'b1;
    repeat (51) @(negedge clk);
    bus.step_div = 24'd10;
    @(negedge clk);
    chk("shrink_next", int'(bus.step_pulse), 1);
    wait_gap(gap, 30);
    chk("period_11", gap, 11);
    bus.step_div = 24'd0;
    cnt = 0;
    repeat (5) begin @(negedge clk); if (bus.step_pulse) cnt++; end
    chk("div0_every_cycle", cnt, 5);
    bus.enable = 1'b0;
    @(negedge clk);

    // Clear at p=7 on a divider terminal
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.step_div = 24'd3; bus.dir = 1'b1; bus.enable = 1'b1;
    collect(7, 60);
    chk("p7_pos", pos_q.size() == 7 ? pos_q[6] : -1, 12);
    repeat (3) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("clr_run_pos", int'(bus.row) * 8 + int'(bus.col), 0);
    chk("clr_run_nopulse", int'(bus.step_pulse), 0);
    chk("clr_run_running", int'(bus.running), 1);
    wait_gap(gap, 20);
    chk("clr_next_gap", gap, 4);
    chk("clr_next_pos", int'(bus.row) * 8 + int'(bus.col), 1);

    // Asynchronous reset mid-run
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_row", int'(bus.row), 0);
    chk("arst_col", int'(bus.col), 0);
    chk("arst_running", int'(bus.running), 0);
    chk("arst_step", int'(bus.step_pulse), 0);
    chk("arst_lap", int'(bus.lap_pulse), 0);
    @(negedge clk);
    bus.enable = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
